// File: rtl/axis_to_d5m_tx.sv
// axis_to_d5m_tx: turns an AXI4-Stream RGB frame back into a D5M-style raster
// (pixel bus plus frame-valid/line-valid strobes, programmable blanking).
// Beats are buffered in a small FIFO. A count-based raster FSM drains it one
// full line at a time, so a line is never broken. When the source starves,
// horizontal blanking is stretched instead.
//
// Handshake: a beat is transferred on any rising ACLK edge where
// rgb_s_axis_tvalid && rgb_s_axis_tready. tready is simply "FIFO not full"
// (forced low while ARESETN is low), so a beat is never lost or duplicated.
module axis_to_d5m_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 64,
  parameter int H_BLANK    = 16,
  parameter int V_ACTIVE   = 48,
  parameter int V_BLANK    = 4,
  parameter int FIFO_DEPTH = 128
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  iEnable,
  input  logic                  rgb_s_axis_tvalid,
  output logic                  rgb_s_axis_tready,
  input  logic                  rgb_s_axis_tuser,
  input  logic                  rgb_s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] rgb_s_axis_tdata,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  ofval,
  output logic                  olval,
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count,
  output logic                  err_tlast,
  output logic                  err_sof,
  output logic [2:0]            o_dbg_state
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CNTW   = AW + 1;
  localparam int EW     = DATA_WIDTH + 2;
  localparam int VB_CYC = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int TMAX0  = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
  localparam int TMAX   = (VB_CYC > TMAX0) ? VB_CYC : TMAX0;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int LW     = $clog2(V_ACTIVE + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3,
    S_VBLANK = 3'd4
  } state_t;

  // FIFO storage and pointers
  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CNTW-1:0]       r_count;

  // Raster FSM state
  state_t                r_state;
  logic [TW-1:0]         r_cnt;
  logic [LW-1:0]         r_line;
  logic                  r_ofval;
  logic                  r_olval;
  logic [DATA_WIDTH-1:0] r_odata;
  logic [15:0]           r_frame_count;
  logic [15:0]           r_drop_count;
  logic                  r_err_tlast;
  logic                  r_err_sof;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_has_line;
  logic [EW-1:0]         w_head;
  logic                  w_head_user;
  logic                  w_head_last;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_last_pix;
  logic                  w_first_pix;
  logic                  w_blank_done;
  logic                  w_last_line;
  logic                  w_vb_done;

  assign w_full            = (r_count == CNTW'(FIFO_DEPTH));
  assign w_empty           = (r_count == '0);
  assign rgb_s_axis_tready = ARESETN && !w_full;
  assign w_push            = rgb_s_axis_tvalid && rgb_s_axis_tready;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_user = w_head[EW-1];
  assign w_head_last = w_head[EW-2];
  assign w_head_data = w_head[DATA_WIDTH-1:0];

  // Pre-SOF beats are discarded in IDLE; ACTIVE consumes one pixel per cycle.
  // ACTIVE is only entered with a full line buffered, so it never pops empty.
  assign w_drop     = (r_state == S_IDLE) && !w_empty && !w_head_user;
  assign w_pop      = w_drop || (r_state == S_ACTIVE);
  assign w_has_line = (r_count >= CNTW'(H_ACTIVE));

  assign w_last_pix   = (r_cnt == TW'(H_ACTIVE - 1));
  assign w_first_pix  = (r_cnt == '0) && (r_line == '0);
  assign w_blank_done = (r_cnt >= TW'(H_BLANK - 1));
  assign w_last_line  = (r_line == LW'(V_ACTIVE - 1));
  assign w_vb_done    = (r_cnt == TW'(VB_CYC - 1));

  // FIFO storage write (contents are don't-care while empty, so no reset)
  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {rgb_s_axis_tuser, rgb_s_axis_tlast, rgb_s_axis_tdata};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Raster FSM with registered strobes, pixel data, counters and sticky errors
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_line        <= '0;
      r_ofval       <= 1'b0;
      r_olval       <= 1'b0;
      r_odata       <= '0;
      r_frame_count <= '0;
      r_drop_count  <= '0;
      r_err_tlast   <= 1'b0;
      r_err_sof     <= 1'b0;
    end else begin
      // Strobes follow the state one cycle later, in step with the popped pixel.
      r_ofval <= (r_state == S_PRE) || (r_state == S_ACTIVE) || (r_state == S_HBLANK);
      r_olval <= (r_state == S_ACTIVE);
      r_odata <= (r_state == S_ACTIVE) ? w_head_data : '0;

      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_line <= '0;
          if (w_drop) begin
            if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
          end else if (!w_empty && w_head_user && iEnable && w_has_line) begin
            r_state <= S_PRE;
          end
        end
        S_PRE: begin
          if (w_blank_done) begin
            r_state <= S_ACTIVE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACTIVE: begin
          if (w_head_last != w_last_pix) r_err_tlast <= 1'b1;
          if (w_head_user && !w_first_pix) r_err_sof <= 1'b1;
          if (w_last_pix) begin
            r_state <= S_HBLANK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HBLANK: begin
          if (!w_blank_done) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_last_line) begin
            r_state       <= S_VBLANK;
            r_cnt         <= '0;
            r_frame_count <= r_frame_count + 16'd1;
          end else if (w_has_line) begin
            r_state <= S_ACTIVE;
            r_cnt   <= '0;
            r_line  <= r_line + 1'b1;
          end
        end
        S_VBLANK: begin
          if (w_vb_done) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign odata       = r_odata;
  assign ofval       = r_ofval;
  assign olval       = r_olval;
  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;
  assign err_tlast   = r_err_tlast;
  assign err_sof     = r_err_sof;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axis_to_d5m_tx.sv
// Bench for axis_to_d5m_tx with a small raster (4x3 active, 2/1 blanking, 8-deep FIFO).
module tb_axis_to_d5m_tx;

  localparam int DW  = 24;
  localparam int HA  = 4;
  localparam int HB  = 2;
  localparam int VA  = 3;
  localparam int VB  = 1;
  localparam int FD  = 8;
  localparam int VBC = VB * (HA + HB);

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          iEnable = 1'b1;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          tuser = 1'b0;
  logic          tlast = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [DW-1:0] odata;
  logic          ofval;
  logic          olval;
  logic [15:0]   frame_count;
  logic [15:0]   drop_count;
  logic          err_tlast;
  logic          err_sof;
  logic [2:0]    dbg_state;

  logic [DW-1:0] exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  bit            saw_stall;

  axis_to_d5m_tx #(
    .DATA_WIDTH(DW), .H_ACTIVE(HA), .H_BLANK(HB),
    .V_ACTIVE(VA), .V_BLANK(VB), .FIFO_DEPTH(FD)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .iEnable(iEnable),
    .rgb_s_axis_tvalid(tvalid),
    .rgb_s_axis_tready(tready),
    .rgb_s_axis_tuser(tuser),
    .rgb_s_axis_tlast(tlast),
    .rgb_s_axis_tdata(tdata),
    .odata(odata),
    .ofval(ofval),
    .olval(olval),
    .frame_count(frame_count),
    .drop_count(drop_count),
    .err_tlast(err_tlast),
    .err_sof(err_sof),
    .o_dbg_state(dbg_state)
  );

  // Clock
  initial forever #5 ACLK = ~ACLK;

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge ACLK);
    tvalid  = 1'b0;
    ARESETN = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    exp_q.delete();
  endtask

  // Present one beat from a negedge; it transfers on the next posedge that sees tready.
  task automatic send_beat(input logic [DW-1:0] d, input bit u, input bit l, input bit keep);
    int t;
    t = 0;
    @(negedge ACLK);
    tvalid = 1'b1; tdata = d; tuser = u; tlast = l;
    while (tready !== 1'b1 && t < 500) begin
      saw_stall = 1'b1;
      @(negedge ACLK);
      t++;
    end
    if (tready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL beat_accept: tready=%b required 1 within 500 cycles", tready);
      tvalid = 1'b0;
      return;
    end
    @(posedge ACLK);
    if (keep) exp_q.push_back(d);
    #1 tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base);
    for (int i = 0; i < HA * VA; i++)
      send_beat(base + DW'(i), (i == 0), ((i % HA) == HA - 1), 1'b1);
  endtask

  // Scoreboard side: follows one frame on the raster and pops exp_q per olval cycle.
  task automatic watch_frame(input int exp_len, input bit exact_gap, output int fl);
    int t, run, bursts, pre, gap;
    bit seen_line;
    logic [DW-1:0] e;
    t = 0; fl = 0; run = 0; bursts = 0; pre = 0; gap = 0; seen_line = 0;
    while (ofval !== 1'b1 && t < 3000) begin @(negedge ACLK); t++; end
    vectors++;
    if (ofval !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_start: ofval=%b required 1 within 3000 cycles", ofval);
      return;
    end
    while (ofval === 1'b1 && fl < 3000) begin
      if (olval === 1'b1) begin
        if (run == 0) begin
          vectors++;
          if (!seen_line) begin
            if (pre != HB) begin
              miscompares++;
              $display("FAIL pre_blank: got %0d cycles, required %0d", pre, HB);
            end
          end else if (exact_gap ? (gap != HB) : (gap < HB)) begin
            miscompares++;
            $display("FAIL hblank_gap: got %0d cycles, required %s%0d", gap, exact_gap ? "" : ">=", HB);
          end
        end
        run++; seen_line = 1'b1;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL odata_extra: got %h, required no pixel", odata);
        end else begin
          e = exp_q.pop_front();
          if (odata !== e) begin
            miscompares++;
            $display("FAIL odata: got %h, required %h", odata, e);
          end
        end
      end else begin
        if (run != 0) begin
          vectors++;
          if (run != HA) begin
            miscompares++;
            $display("FAIL burst_len: got %0d, required %0d", run, HA);
          end
          bursts++; run = 0; gap = 0;
        end
        if (!seen_line) pre++; else gap++;
        vectors++;
        if (odata !== '0) begin
          miscompares++;
          $display("FAIL odata_blank: got %h, required 0", odata);
        end
      end
      fl++;
      @(negedge ACLK);
    end
    vectors++;
    if (bursts != VA) begin
      miscompares++;
      $display("FAIL line_count: got %0d, required %0d", bursts, VA);
    end
    if (exp_len > 0) begin
      vectors++;
      if (fl != exp_len) begin
        miscompares++;
        $display("FAIL fval_len: got %0d, required %0d", fl, exp_len);
      end
    end
    for (int i = 0; i < VBC; i++) begin
      vectors++;
      if (ofval !== 1'b0 || olval !== 1'b0) begin
        miscompares++;
        $display("FAIL vblank: ofval=%b olval=%b at %0d, required 0 0", ofval, olval, i);
      end
      @(negedge ACLK);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge ACLK);
    vectors++;
    if ({ofval, olval, odata, frame_count, drop_count, err_tlast, err_sof, tready} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ofval=%b olval=%b odata=%h fc=%h dc=%h et=%b es=%b tready=%b required all 0",
               ofval, olval, odata, frame_count, drop_count, err_tlast, err_sof, tready);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    vectors++;
    if (tready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_tready: got %b, required 1", tready);
    end
  endtask

  task automatic test_continuous();
    int fl;
    apply_reset();
    fork
      send_frame(24'h000001);
      watch_frame(VA * (HA + HB) + HB, 1'b1, fl);
    join
    vectors++;
    if (frame_count !== 16'd1 || err_tlast !== 1'b0 || err_sof !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_status: fc=%0d et=%b es=%b, required 1 0 0", frame_count, err_tlast, err_sof);
    end
  endtask

  task automatic test_drop();
    int fl;
    apply_reset();
    fork
      begin
        for (int i = 0; i < 3; i++) send_beat(DW'($urandom_range(1, 255)), 1'b0, 1'b0, 1'b0);
        send_frame(24'h000001);
      end
      watch_frame(VA * (HA + HB) + HB, 1'b1, fl);
    join
    vectors++;
    if (drop_count !== 16'd3 || frame_count !== 16'd1) begin
      miscompares++;
      $display("FAIL drop_count: dc=%0d fc=%0d, required 3 1", drop_count, frame_count);
    end
  endtask

  task automatic test_tlast_error();
    int fl;
    apply_reset();
    fork
      for (int i = 1; i <= HA * VA; i++)
        send_beat(DW'(i), (i == 1), (i == 3) || (i == 8) || (i == 12), 1'b1);
      watch_frame(VA * (HA + HB) + HB, 1'b1, fl);
    join
    vectors++;
    if (err_tlast !== 1'b1 || err_sof !== 1'b0) begin
      miscompares++;
      $display("FAIL tlast_err: et=%b es=%b, required 1 0", err_tlast, err_sof);
    end
    repeat (10) @(negedge ACLK);
    vectors++;
    if (err_tlast !== 1'b1) begin
      miscompares++;
      $display("FAIL tlast_sticky: got %b, required 1", err_tlast);
    end
  endtask

  task automatic test_sof_error();
    int fl;
    apply_reset();
    fork
      for (int i = 1; i <= HA * VA; i++)
        send_beat(DW'(i) + 24'h100, (i == 1) || (i == 7), (i % HA) == 0, 1'b1);
      watch_frame(VA * (HA + HB) + HB, 1'b1, fl);
    join
    vectors++;
    if (err_sof !== 1'b1 || err_tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL sof_err: es=%b et=%b, required 1 0", err_sof, err_tlast);
    end
  endtask

  task automatic test_stall();
    int fl;
    apply_reset();
    fork
      begin
        for (int i = 1; i <= HA * VA; i++) begin
          send_beat(DW'(i) + 24'hA000, (i == 1), (i % HA) == 0, 1'b1);
          if (i == 6) repeat (10) @(negedge ACLK);
        end
      end
      watch_frame(0, 1'b0, fl);
    join
    vectors++;
    if (fl <= VA * (HA + HB) + HB) begin
      miscompares++;
      $display("FAIL stall_stretch: fval_len=%0d, required > %0d", fl, VA * (HA + HB) + HB);
    end
  endtask

  task automatic test_back_to_back();
    int fl;
    apply_reset();
    saw_stall = 1'b0;
    fork
      begin
        send_frame(24'h010000);
        send_frame(24'h020000);
      end
      begin
        watch_frame(VA * (HA + HB) + HB, 1'b1, fl);
        watch_frame(VA * (HA + HB) + HB, 1'b1, fl);
      end
    join
    vectors++;
    if (saw_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure: tready low seen=%b, required 1", saw_stall);
    end
    vectors++;
    if (frame_count !== 16'd2 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_status: fc=%0d leftover=%0d, required 2 0", frame_count, exp_q.size());
    end
  endtask

  task automatic test_mid_frame_reset();
    int t, rises, fl;
    logic prev;
    apply_reset();
    fork
      send_frame(24'h000050);
      begin
        t = 0; rises = 0; prev = 1'b0;
        while (rises < 2 && t < 500) begin
          @(negedge ACLK);
          if (olval === 1'b1 && prev !== 1'b1) rises++;
          prev = olval;
          t++;
        end
        vectors++;
        if (rises < 2) begin
          miscompares++;
          $display("FAIL line2_start: lines seen=%0d, required 2", rises);
        end
      end
    join
    @(negedge ACLK);
    #2 ARESETN = 1'b0;
    #1;
    vectors++;
    if ({ofval, olval, odata, frame_count, drop_count, err_tlast, err_sof, tready} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: ofval=%b olval=%b odata=%h fc=%h dc=%h tready=%b required all 0",
               ofval, olval, odata, frame_count, drop_count, tready);
    end
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    exp_q.delete();
    repeat (10) begin
      @(negedge ACLK);
      vectors++;
      if (ofval !== 1'b0 || drop_count !== 16'd0) begin
        miscompares++;
        $display("FAIL fifo_flushed: ofval=%b dc=%0d, required 0 0", ofval, drop_count);
      end
    end
    vectors++;
    if (frame_count !== 16'd0) begin
      miscompares++;
      $display("FAIL fc_restart: got %0d, required 0", frame_count);
    end
    fork
      send_frame(24'h000001);
      watch_frame(VA * (HA + HB) + HB, 1'b1, fl);
    join
    vectors++;
    if (frame_count !== 16'd1) begin
      miscompares++;
      $display("FAIL fc_after_reset: got %0d, required 1", frame_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_continuous();
    test_drop();
    test_tlast_error();
    test_sof_error();
    test_stall();
    test_back_to_back();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
